// File: rtl/nibble_exec_seq.sv
// rtl/nibble_exec_seq.sv - nibble-serial execute stage with integrated register file
module nibble_exec_seq #(
  parameter  int NIBBLES = 8,
  parameter  int REGS    = 32,
  parameter  int CMD_W   = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int AW      = $clog2(REGS),
  localparam int IW      = $clog2(NIBBLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_op,
  input  logic             cmd_reverse,
  input  logic             cmd_carry0,
  input  logic [AW-1:0]    cmd_rs1,
  input  logic [AW-1:0]    cmd_rs2,
  input  logic [AW-1:0]    cmd_rd,
  output logic [CMD_W-1:0] nib_cmd,
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b,
  output logic             nib_cin,
  input  logic [3:0]       nib_res,
  input  logic             nib_cout,
  output logic             done,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [W-1:0]     ld_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [W-1:0]     dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t             state;
  logic [W-1:0]       regs [REGS];

  logic [CMD_W-1:0]   op_q;
  logic               rev_q;
  logic               c0_q;
  logic [AW-1:0]      rs1_q;
  logic [AW-1:0]      rs2_q;
  logic [AW-1:0]      rd_q;
  logic [W-1:0]       opa;
  logic [W-1:0]       opb;
  logic [W-1:0]       result;
  logic [IW-1:0]      idx;

  logic [W-1:0]       rd_a;
  logic [W-1:0]       rd_b;
  logic [IW-1:0]      start_idx;
  logic [IW-1:0]      idx_next;
  logic               last_nib;
  logic               carry_next;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [W-1:0]       wr_data;

  // Nibble i of a word; the {i,2'b00} index keeps the bit offset wide enough.
  function automatic logic [3:0] get_nib(input logic [W-1:0] w, input logic [IW-1:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  // Operand reads, sequencing helpers and the shared register-file write port.
  always_comb begin
    rd_a       = (rs1_q == '0) ? '0 : regs[rs1_q];
    rd_b       = (rs2_q == '0) ? '0 : regs[rs2_q];
    start_idx  = rev_q ? IW'(NIBBLES - 1) : '0;
    idx_next   = rev_q ? (idx - 1'b1) : (idx + 1'b1);
    last_nib   = rev_q ? (idx == '0) : (idx == IW'(NIBBLES - 1));
    // Right shifts chain the bit shifted out of b; arithmetic chains the ALU carry.
    carry_next = rev_q ? nib_b[0] : nib_cout;
    dbg_data   = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    wr_en      = 1'b0;
    wr_addr    = ld_addr;
    wr_data    = ld_data;
    if (state == S_WB) begin
      wr_en   = (rd_q != '0);
      wr_addr = rd_q;
      wr_data = result;
    end else if (state == S_IDLE) begin
      wr_en   = ld_en && (ld_addr != '0);
    end
  end

  // Register file; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Control FSM: accept, read operands, stream nibbles through the ALU, write back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      op_q      <= '0;
      rev_q     <= 1'b0;
      c0_q      <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      opa       <= '0;
      opb       <= '0;
      result    <= '0;
      idx       <= '0;
      nib_cmd   <= '0;
      nib_a     <= '0;
      nib_b     <= '0;
      nib_cin   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            rev_q     <= cmd_reverse;
            c0_q      <= cmd_carry0;
            rs1_q     <= cmd_rs1;
            rs2_q     <= cmd_rs2;
            rd_q      <= cmd_rd;
            cmd_ready <= 1'b0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          // Loads made while idle have already committed, so the file is current.
          opa     <= rd_a;
          opb     <= rd_b;
          result  <= '0;
          idx     <= start_idx;
          nib_cmd <= op_q;
          nib_a   <= get_nib(rd_a, start_idx);
          nib_b   <= get_nib(rd_b, start_idx);
          nib_cin <= c0_q;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          result[{idx, 2'b00} +: 4] <= nib_res;
          if (last_nib) begin
            // Drop the ALU drive so no carry or operand leaks into the next op.
            nib_cmd <= '0;
            nib_a   <= '0;
            nib_b   <= '0;
            nib_cin <= 1'b0;
            idx     <= '0;
            done    <= 1'b1;
            state   <= S_WB;
          end else begin
            idx     <= idx_next;
            nib_a   <= get_nib(opa, idx_next);
            nib_b   <= get_nib(opb, idx_next);
            nib_cin <= carry_next;
          end
        end
        S_WB: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
